bit_pattern_tx: RTL and testbench

//  Serial bit-pattern transmitter: sends a programmable PAT_W-bit pattern, MSB first,
//  one bit per clk on sout, repeated reps times with gap idle cycles between repeats.

---
 rtl/bit_pattern_tx.sv | 145 ++++++++++++++
 tb/tb_bit_pattern_tx.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/bit_pattern_tx.sv
// bit_pattern_tx: serial pattern transmitter, MSB first.
// Sends a captured pattern reps times with idle gaps between.
module bit_pattern_tx #(
    parameter int PAT_W = 4,
    parameter int REP_W = 4,
    parameter int GAP_W = 3
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [PAT_W-1:0] pat,
    input  logic [REP_W-1:0] reps,
    input  logic [GAP_W-1:0] gap,
    input  logic             abort,
    output logic             ready,
    output logic             busy,
    output logic             sout,
    output logic             sout_valid,
    output logic             frame_last,
    output logic             done
);

    localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(PAT_W - 1);
    localparam logic [GAP_W-1:0] GAP_ONE = GAP_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_GAP,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
    logic [REP_W-1:0] rep_left_q, rep_left_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;

    // State and datapath registers, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            pat_q      <= '0;
            gap_q      <= '0;
            bit_idx_q  <= '0;
            rep_left_q <= '0;
            gap_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            pat_q      <= pat_d;
            gap_q      <= gap_d;
            bit_idx_q  <= bit_idx_d;
            rep_left_q <= rep_left_d;
            gap_cnt_q  <= gap_cnt_d;
        end
    end

    // Next-state: accept, bit stepping, repeat and gap sequencing, abort.
    always_comb begin
        state_d    = state_q;
        pat_d      = pat_q;
        gap_d      = gap_q;
        bit_idx_d  = bit_idx_q;
        rep_left_d = rep_left_q;
        gap_cnt_d  = gap_cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    pat_d      = pat;
                    gap_d      = gap;
                    bit_idx_d  = IDX_MAX;
                    rep_left_d = (reps == '0) ? '0 : reps - 1'b1;
                    state_d    = S_SEND;
                end
            end
            S_SEND: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (bit_idx_q == '0) begin
                    if (rep_left_q == '0) begin
                        state_d = S_DONE;
                    end else begin
                        rep_left_d = rep_left_q - 1'b1;
                        bit_idx_d  = IDX_MAX;
                        if (gap_q != '0) begin
                            gap_cnt_d = gap_q;
                            state_d   = S_GAP;
                        end
                    end
                end else begin
                    bit_idx_d = bit_idx_q - 1'b1;
                end
            end
            S_GAP: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (gap_cnt_q <= GAP_ONE) begin
                    state_d = S_SEND;
                end else begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decoded purely from registered state.
    always_comb begin
        ready      = 1'b0;
        busy       = 1'b0;
        sout       = 1'b0;
        sout_valid = 1'b0;
        frame_last = 1'b0;
        done       = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                ready = 1'b1;
            end
            S_SEND: begin
                busy       = 1'b1;
                sout_valid = 1'b1;
                sout       = pat_q[bit_idx_q];
                frame_last = (bit_idx_q == '0) && (rep_left_q == '0);
            end
            S_GAP: begin
                busy = 1'b1;
            end
            S_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                ready = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_bit_pattern_tx.sv
// tb_bit_pattern_tx: table vectors, corner sequences and random
// transfers checked against a per-cycle expected-output model.
module tb_bit_pattern_tx;

    logic       clk = 1'b0;
    logic       rstn;
    logic       start;
    logic [3:0] pat;
    logic [3:0] reps_i;
    logic [2:0] gap_i;
    logic       abort;
    logic       ready, busy, sout, sout_valid, frame_last, done;

    int n_chk  = 0;
    int n_fail = 0;

    // {sout, sout_valid, frame_last, done} expected per cycle
    logic [3:0] exp_q[$];

    typedef struct {
        string      name;
        logic [3:0] pat;
        int         reps;
        int         gap;
        int         abort_at;
        int         mid_start;
        int         exp_done;
        int         exp_det;
    } vec_t;

    vec_t vecs[10];

    bit_pattern_tx #(.PAT_W(4), .REP_W(4), .GAP_W(3)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .pat        (pat),
        .reps       (reps_i),
        .gap        (gap_i),
        .abort      (abort),
        .ready      (ready),
        .busy       (busy),
        .sout       (sout),
        .sout_valid (sout_valid),
        .frame_last (frame_last),
        .done       (done)
    );

    always #5 clk = ~clk;

    function automatic int obs();
        return int'({sout, sout_valid, frame_last, done, busy, ready});
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Expected waveform: R patterns MSB first, G idles between, then DONE.
    task automatic build_model(input logic [3:0] p, input int reps, input int g);
        int r;
        r = (reps == 0) ? 1 : reps;
        exp_q.delete();
        for (int k = 0; k < r; k++) begin
            for (int b = 3; b >= 0; b--)
                exp_q.push_back({p[b], 1'b1, (k == r - 1) && (b == 0), 1'b0});
            if (k < r - 1)
                for (int j = 0; j < g; j++) exp_q.push_back(4'b0000);
        end
        exp_q.push_back(4'b0001);
    endtask

    task automatic run(input string nm, input logic [3:0] p, input int reps,
                       input int g, input int abort_at, input int mid_start,
                       output int done_cyc, output int det);
        int         len;
        int         nbits;
        logic [3:0] sh;
        build_model(p, reps, g);
        len      = exp_q.size();
        done_cyc = 0;
        det      = 0;
        nbits    = 0;
        sh       = 4'b0;
        @(negedge clk);
        chk({nm, "_pre"}, obs(), 6'b000001);
        pat    = p;
        reps_i = 4'(reps);
        gap_i  = 3'(g);
        start  = 1'b1;
        for (int i = 1; i <= len; i++) begin
            @(negedge clk);
            start  = 1'b0;
            abort  = 1'b0;
            pat    = 4'($urandom);
            reps_i = 4'($urandom);
            gap_i  = 3'($urandom);
            chk($sformatf("%s_c%0d", nm, i), obs(), int'({exp_q[i-1], 2'b10}));
            if (done) done_cyc = i;
            if (sout_valid) begin
                sh = {sh[2:0], sout};
                nbits++;
                if (nbits >= 4 && sh == 4'b1011) det++;
            end
            if (i == abort_at) begin
                abort = 1'b1;
                break;
            end
            if (i == mid_start) start = 1'b1;
        end
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk({nm, "_end"}, obs(), 6'b000001);
    endtask

    initial begin
        int dc, dt, r, g, len, ab;

        vecs[0] = '{"single",   4'b1011,  1, 0, 0, 0,   5,  1};
        vecs[1] = '{"reps3g2",  4'b1011,  3, 2, 0, 0,  17,  3};
        vecs[2] = '{"b2b",      4'b1011,  2, 0, 0, 0,   9,  2};
        vecs[3] = '{"reps0",    4'b1011,  0, 0, 0, 0,   5,  1};
        vecs[4] = '{"abort2",   4'b1011,  2, 1, 2, 0,   0,  0};
        vecs[5] = '{"ignstart", 4'b1011,  1, 0, 0, 2,   5,  1};
        vecs[6] = '{"maxreps",  4'b1011, 15, 7, 0, 0, 159, 15};
        vecs[7] = '{"abortlst", 4'b1011,  1, 0, 4, 0,   0,  1};
        vecs[8] = '{"abortgap", 4'b0110,  2, 3, 6, 0,   0,  0};
        vecs[9] = '{"gap1rep",  4'b0001,  1, 5, 0, 0,   5,  0};

        rstn   = 1'b0;
        start  = 1'b0;
        abort  = 1'b0;
        pat    = 4'b1011;
        reps_i = 4'd1;
        gap_i  = 3'd0;

        // reset held three cycles with start toggling
        for (int i = 0; i < 3; i++) begin
            start = ~start;
            @(negedge clk);
            chk($sformatf("reset_%0d", i), obs(), 6'b000001);
        end
        start = 1'b0;
        rstn  = 1'b1;
        @(negedge clk);
        chk("reset_rel", obs(), 6'b000001);

        foreach (vecs[v]) begin
            run(vecs[v].name, vecs[v].pat, vecs[v].reps, vecs[v].gap,
                vecs[v].abort_at, vecs[v].mid_start, dc, dt);
            chk({vecs[v].name, "_donecyc"}, dc, vecs[v].exp_done);
            chk({vecs[v].name, "_det"}, dt, vecs[v].exp_det);
        end

        // abort and start together in IDLE: abort wins
        @(negedge clk);
        pat    = 4'b1011;
        reps_i = 4'd1;
        gap_i  = 3'd0;
        start  = 1'b1;
        abort  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            start = 1'b0;
            abort = 1'b0;
            chk($sformatf("abst_%0d", i), obs(), 6'b000001);
        end

        // reset in the middle of a transfer
        pat    = 4'b1011;
        reps_i = 4'd3;
        gap_i  = 3'd0;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("mrst_c1", obs(), 6'b110010);
        @(negedge clk);
        chk("mrst_c2", obs(), 6'b010010);
        @(negedge clk);
        chk("mrst_c3", obs(), 6'b110010);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        chk("mrst_c4", obs(), 6'b000001);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("mrst_idle%0d", i), obs(), 6'b000001);
        end
        run("post_rst", 4'b1011, 1, 0, 0, 0, dc, dt);
        chk("post_rst_donecyc", dc, 5);
        chk("post_rst_det", dt, 1);

        // random transfers, some aborted
        for (int t = 0; t < 40; t++) begin
            r   = $urandom_range(0, 6);
            g   = $urandom_range(0, 7);
            len = ((r == 0) ? 1 : r) * 4 + (((r == 0) ? 1 : r) - 1) * g + 1;
            ab  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, len - 1) : 0;
            run($sformatf("rnd%0d", t), 4'($urandom), r, g, ab, 0, dc, dt);
            chk($sformatf("rnd%0d_donecyc", t), dc, (ab != 0) ? 0 : len);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
